// File: rtl/share_mem_wr_arbiter_pkg.sv
// Shared constants and FSM state encoding for the shared-memory write arbiter.
// Used by share_mem_wr_arbiter and any read-side scheduler built on the same ports.
package share_mem_wr_arbiter_pkg;

    localparam int PORT_NUB_TOTAL = 4;
    localparam int DATA_WIDTH     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        REL  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/share_mem_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester found scanning ptr, ptr+1, ...
// modulo PORT_NUB. Returns the one-hot select, its index and whether any request was seen.
module share_mem_wr_arbiter_rr_pick #(
    parameter int PORT_NUB  = 4,
    parameter int WIDTH_SEL = $clog2(PORT_NUB)
) (
    input  logic [PORT_NUB-1:0]  req,
    input  logic [WIDTH_SEL-1:0] ptr,
    output logic [PORT_NUB-1:0]  pick_onehot,
    output logic [WIDTH_SEL-1:0] pick_idx,
    output logic                 pick_valid
);

    logic [WIDTH_SEL-1:0] cand_idx [PORT_NUB];
    logic [PORT_NUB-1:0]  cand_req;

    // Candidate gi is the port gi places after ptr, wrapped without a modulo operator.
    genvar gi;
    generate
        for (gi = 0; gi < PORT_NUB; gi++) begin : g_cand
            logic [WIDTH_SEL:0] sum;
            assign sum = {1'b0, ptr} + (WIDTH_SEL+1)'(gi);
            assign cand_idx[gi] = (sum >= (WIDTH_SEL+1)'(PORT_NUB))
                                ? WIDTH_SEL'(sum - (WIDTH_SEL+1)'(PORT_NUB))
                                : WIDTH_SEL'(sum);
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        pick_idx = '0;
        for (int k = PORT_NUB - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                pick_idx = cand_idx[k];
            end
        end
        pick_valid  = |req;
        pick_onehot = pick_valid ? (PORT_NUB'(1) << pick_idx) : '0;
    end

endmodule

// File: rtl/share_mem_wr_arbiter.sv
// Round-robin, burst-locked arbiter for the shared-memory write port.
// Optional idle-owner watchdog enabled by defining ARB_WATCHDOG_EN.
module share_mem_wr_arbiter #(
    parameter int PORT_NUB   = share_mem_wr_arbiter_pkg::PORT_NUB_TOTAL,
    parameter int WIDTH_SEL  = $clog2(PORT_NUB),
    parameter int DATA_WIDTH = share_mem_wr_arbiter_pkg::DATA_WIDTH,
    parameter int MAX_BURST  = 16
`ifdef ARB_WATCHDOG_EN
    ,
    parameter int TIMEOUT    = 32
`endif
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [PORT_NUB-1:0]             in_req,
    input  logic [PORT_NUB-1:0]             in_vaild,
    input  logic [PORT_NUB-1:0]             in_done,
    input  logic [PORT_NUB*WIDTH_SEL-1:0]   in_rx_port,
    input  logic [PORT_NUB*DATA_WIDTH-1:0]  in_data,
    input  logic                            mem_ready,
    output logic [PORT_NUB-1:0]             grant,
    output logic                            out_vaild,
    output logic [WIDTH_SEL-1:0]            out_tx_port,
    output logic [WIDTH_SEL-1:0]            out_rx_port,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_sop,
    output logic                            out_eop,
    output logic [$clog2(MAX_BURST+1)-1:0]  out_len,
    output logic                            busy,
    output logic                            err
);
    import share_mem_wr_arbiter_pkg::*;

    localparam int LEN_W = $clog2(MAX_BURST + 1);

    arb_state_t state_reg, state_next;
    logic [WIDTH_SEL-1:0]  owner_reg, owner_next;
    logic [WIDTH_SEL-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [LEN_W-1:0]      beat_cnt_reg, beat_cnt_next;
    logic                  ovf_reg, ovf_next;
    logic [PORT_NUB-1:0]   grant_reg, grant_next;
    logic                  vaild_reg, vaild_next;
    logic [WIDTH_SEL-1:0]  tx_reg, tx_next;
    logic [WIDTH_SEL-1:0]  rx_reg, rx_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic                  sop_reg, sop_next;
    logic                  eop_reg, eop_next;
    logic [LEN_W-1:0]      len_reg, len_next;
    logic                  err_reg, err_next;
`ifdef ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0]       wd_cnt_reg, wd_cnt_next;
`endif

    logic [PORT_NUB-1:0]   pick_onehot;
    logic [WIDTH_SEL-1:0]  pick_idx;
    logic                  pick_valid;

    logic [WIDTH_SEL-1:0]  rx_arr   [PORT_NUB];
    logic [DATA_WIDTH-1:0] data_arr [PORT_NUB];

    genvar gi;
    generate
        for (gi = 0; gi < PORT_NUB; gi++) begin : g_unpack
            assign rx_arr[gi]   = in_rx_port[gi*WIDTH_SEL +: WIDTH_SEL];
            assign data_arr[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    share_mem_wr_arbiter_rr_pick #(
        .PORT_NUB  (PORT_NUB),
        .WIDTH_SEL (WIDTH_SEL)
    ) u_rr_pick (
        .req         (in_req),
        .ptr         (rr_ptr_reg),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx),
        .pick_valid  (pick_valid)
    );

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        rr_ptr_next   = rr_ptr_reg;
        beat_cnt_next = beat_cnt_reg;
        ovf_next      = ovf_reg;
        grant_next    = grant_reg;
        vaild_next    = 1'b0;
        tx_next       = '0;
        rx_next       = '0;
        data_next     = '0;
        sop_next      = 1'b0;
        eop_next      = 1'b0;
        len_next      = '0;
        err_next      = 1'b0;
`ifdef ARB_WATCHDOG_EN
        wd_cnt_next   = '0;
`endif
        unique case (state_reg)
            IDLE: begin
                if (pick_valid && mem_ready) begin
                    owner_next    = pick_idx;
                    grant_next    = pick_onehot;
                    beat_cnt_next = '0;
                    ovf_next      = 1'b0;
                    state_next    = XFER;
                end
            end
            XFER: begin
                if (in_vaild[owner_reg]) begin
                    if (beat_cnt_reg < LEN_W'(MAX_BURST)) begin
                        vaild_next    = 1'b1;
                        tx_next       = owner_reg;
                        rx_next       = rx_arr[owner_reg];
                        data_next     = data_arr[owner_reg];
                        sop_next      = (beat_cnt_reg == '0);
                        beat_cnt_next = beat_cnt_reg + 1'b1;
                    end else if (!ovf_reg) begin
                        // Only the first dropped beat of a burst raises err.
                        err_next = 1'b1;
                        ovf_next = 1'b1;
                    end
                end
`ifdef ARB_WATCHDOG_EN
                wd_cnt_next = in_vaild[owner_reg] ? '0 : wd_cnt_reg + 1'b1;
`endif
                if (in_done[owner_reg]) begin
                    grant_next = '0;
                    state_next = REL;
                end
`ifdef ARB_WATCHDOG_EN
                else if (!in_vaild[owner_reg] && wd_cnt_reg == WD_W'(TIMEOUT - 1)) begin
                    grant_next = '0;
                    err_next   = 1'b1;
                    state_next = REL;
                end
`endif
            end
            REL: begin
                eop_next      = 1'b1;
                len_next      = beat_cnt_reg;
                rr_ptr_next   = (owner_reg == WIDTH_SEL'(PORT_NUB - 1)) ? '0 : owner_reg + 1'b1;
                beat_cnt_next = '0;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            owner_reg    <= '0;
            rr_ptr_reg   <= '0;
            beat_cnt_reg <= '0;
            ovf_reg      <= 1'b0;
            grant_reg    <= '0;
            vaild_reg    <= 1'b0;
            tx_reg       <= '0;
            rx_reg       <= '0;
            data_reg     <= '0;
            sop_reg      <= 1'b0;
            eop_reg      <= 1'b0;
            len_reg      <= '0;
            err_reg      <= 1'b0;
`ifdef ARB_WATCHDOG_EN
            wd_cnt_reg   <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            rr_ptr_reg   <= rr_ptr_next;
            beat_cnt_reg <= beat_cnt_next;
            ovf_reg      <= ovf_next;
            grant_reg    <= grant_next;
            vaild_reg    <= vaild_next;
            tx_reg       <= tx_next;
            rx_reg       <= rx_next;
            data_reg     <= data_next;
            sop_reg      <= sop_next;
            eop_reg      <= eop_next;
            len_reg      <= len_next;
            err_reg      <= err_next;
`ifdef ARB_WATCHDOG_EN
            wd_cnt_reg   <= wd_cnt_next;
`endif
        end
    end

    assign grant       = grant_reg;
    assign out_vaild   = vaild_reg;
    assign out_tx_port = tx_reg;
    assign out_rx_port = rx_reg;
    assign out_data    = data_reg;
    assign out_sop     = sop_reg;
    assign out_eop     = eop_reg;
    assign out_len     = len_reg;
    assign err         = err_reg;
    assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_share_mem_wr_arbiter.sv
// Scoreboard bench for share_mem_wr_arbiter (4 ports, 8-bit data, MAX_BURST=16).
// Watchdog scenario runs only when ARB_WATCHDOG_EN is defined.
module tb_share_mem_wr_arbiter;

    localparam int PN = 4;
    localparam int W  = 2;
    localparam int DW = 8;
    localparam int MB = 16;
    localparam int LW = 5;
    localparam int TO = 32;

    typedef struct {
        bit            is_eop;
        logic [W-1:0]  tx;
        logic [W-1:0]  rx;
        logic [DW-1:0] data;
        logic          sop;
        logic [LW-1:0] len;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [PN-1:0]    in_req, in_vaild, in_done;
    logic [PN*W-1:0]  in_rx_port;
    logic [PN*DW-1:0] in_data;
    logic             mem_ready;
    logic [PN-1:0]    grant;
    logic             out_vaild;
    logic [W-1:0]     out_tx_port, out_rx_port;
    logic [DW-1:0]    out_data;
    logic             out_sop, out_eop;
    logic [LW-1:0]    out_len;
    logic             busy, err;

    int vectors     = 0;
    int miscompares = 0;
    int err_count   = 0;
    int err_expect  = 0;
    exp_t sb[$];

    share_mem_wr_arbiter #(
        .PORT_NUB   (PN),
        .WIDTH_SEL  (W),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_req      (in_req),
        .in_vaild    (in_vaild),
        .in_done     (in_done),
        .in_rx_port  (in_rx_port),
        .in_data     (in_data),
        .mem_ready   (mem_ready),
        .grant       (grant),
        .out_vaild   (out_vaild),
        .out_tx_port (out_tx_port),
        .out_rx_port (out_rx_port),
        .out_data    (out_data),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_len     (out_len),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Output monitor: every beat and every eop must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (err) err_count++;
        vectors++;
        if (out_vaild) begin
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_beat: tx=%0d data=%h, scoreboard empty", out_tx_port, out_data);
            end else begin
                e = sb.pop_front();
                if (e.is_eop || {out_tx_port, out_rx_port, out_data, out_sop} !== {e.tx, e.rx, e.data, e.sop}) begin
                    miscompares++;
                    $display("FAIL beat: got tx=%0d rx=%0d data=%h sop=%b, expected eop=%b tx=%0d rx=%0d data=%h sop=%b",
                             out_tx_port, out_rx_port, out_data, out_sop, e.is_eop, e.tx, e.rx, e.data, e.sop);
                end else begin
                    $display("beat  tx=%0d rx=%0d data=%h sop=%b", out_tx_port, out_rx_port, out_data, out_sop);
                end
            end
        end else if ({out_tx_port, out_rx_port, out_data, out_sop} !== '0) begin
            miscompares++;
            $display("FAIL idle_bus: tx=%0d rx=%0d data=%h sop=%b, expected all 0", out_tx_port, out_rx_port, out_data, out_sop);
        end
        if (out_eop) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_eop: len=%0d, scoreboard empty", out_len);
            end else begin
                e = sb.pop_front();
                if (!e.is_eop || out_len !== e.len) begin
                    miscompares++;
                    $display("FAIL eop: got len=%0d, expected eop=%b len=%0d", out_len, e.is_eop, e.len);
                end else begin
                    $display("eop   len=%0d", out_len);
                end
            end
        end
    end

    task automatic apply_reset();
        rst = 1'b1;
        in_req = '0; in_vaild = '0; in_done = '0;
        in_rx_port = '0; in_data = '0; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(negedge clk);
    endtask

    // Waits for grant, checks owner and wait length, streams nbeats, then done.
    task automatic serve_next(input int port, input int nbeats, input bit done_sep, input bit last,
                              input logic [DW-1:0] base, input int exp_gap, input bit noise);
        int gap;
        exp_t e;
        logic [PN-1:0] oh;
        oh  = 4'b0001 << port;
        gap = 0;
        while (grant === 4'b0000 && gap < 40) begin
            gap++;
            @(negedge clk);
        end
        vectors++;
        if (grant !== oh || gap != exp_gap) begin
            miscompares++;
            $display("FAIL grant_p%0d: grant=%b after %0d cycles, expected %b after %0d", port, grant, gap, oh, exp_gap);
            in_req = '0;
            return;
        end
        $display("grant port=%0d after %0d cycles", port, gap);
        if (last) in_req = '0;
        for (int b = 0; b < nbeats; b++) begin
            in_vaild = noise ? 4'b1111 : oh;
            in_done  = noise ? ~oh : 4'b0000;
            if (!done_sep && b == nbeats - 1) in_done[port] = 1'b1;
            in_data  = noise ? {PN{8'hEE}} : '0;
            in_data[port*DW +: DW]  = base + DW'(b);
            in_rx_port = noise ? 8'hFF : 8'h00;
            in_rx_port[port*W +: W] = W'(3 - port);
            if (b < MB) begin
                e.is_eop = 1'b0; e.tx = W'(port); e.rx = W'(3 - port);
                e.data = base + DW'(b); e.sop = (b == 0); e.len = '0;
                sb.push_back(e);
            end
            @(negedge clk);
        end
        in_vaild = '0; in_done = '0; in_data = '0; in_rx_port = '0;
        e.is_eop = 1'b1; e.tx = '0; e.rx = '0; e.data = '0; e.sop = 1'b0;
        e.len = LW'((nbeats < MB) ? nbeats : MB);
        sb.push_back(e);
        if (done_sep || nbeats == 0) begin
            in_done[port] = 1'b1;
            @(negedge clk);
            in_done = '0;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if ({grant, out_vaild, out_eop, out_len, out_data, busy, err} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: grant=%b vaild=%b eop=%b len=%0d data=%h busy=%b err=%b, expected all 0",
                     grant, out_vaild, out_eop, out_len, out_data, busy, err);
        end
    endtask

    task automatic test_single();
        apply_reset();
        in_req = 4'b0010;
        serve_next(1, 3, 1'b1, 1'b1, 8'h21, 1, 1'b0);
        drain();
        vectors++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL single_end: busy=%b pending=%0d, expected busy=0 pending=0", busy, sb.size());
        end
    endtask

    task automatic test_contention();
        apply_reset();
        in_req = 4'b1111;
        serve_next(0, 1, 1'b0, 1'b0, 8'h40, 1, 1'b1);
        serve_next(1, 1, 1'b0, 1'b0, 8'h41, 2, 1'b1);
        serve_next(2, 1, 1'b0, 1'b0, 8'h42, 2, 1'b1);
        serve_next(3, 1, 1'b0, 1'b0, 8'h43, 2, 1'b1);
        serve_next(0, 1, 1'b0, 1'b1, 8'h44, 2, 1'b1);
        drain();
    endtask

    task automatic test_fairness_wrap();
        apply_reset();
        in_req = 4'b0100;
        serve_next(2, 1, 1'b0, 1'b1, 8'h30, 1, 1'b0);
        in_req = 4'b1001;
        serve_next(3, 2, 1'b1, 1'b0, 8'h50, 2, 1'b0);
        serve_next(0, 1, 1'b0, 1'b1, 8'h60, 2, 1'b0);
        drain();
    endtask

    task automatic test_back_pressure();
        apply_reset();
        mem_ready = 1'b0;
        in_req    = 4'b0001;
        in_done   = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_done = '0;
            vectors++;
            if (grant !== 4'b0000 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL back_pressure: grant=%b busy=%b, expected 0000 and 0", grant, busy);
            end
        end
        mem_ready = 1'b1;
        serve_next(0, 2, 1'b1, 1'b1, 8'h70, 1, 1'b0);
        drain();
    endtask

    task automatic test_overflow();
        apply_reset();
        in_req = 4'b0010;
        serve_next(1, 18, 1'b1, 1'b1, 8'h80, 1, 1'b0);
        err_expect++;
        drain();
    endtask

    task automatic test_zero_beat();
        apply_reset();
        in_req = 4'b0100;
        serve_next(2, 0, 1'b1, 1'b1, 8'h00, 1, 1'b0);
        drain();
    endtask

    task automatic test_reset_mid_burst();
        int n;
        exp_t e;
        apply_reset();
        in_req = 4'b0001;
        n = 0;
        while (grant !== 4'b0001 && n < 10) begin
            n++;
            @(negedge clk);
        end
        in_req = '0;
        in_vaild = 4'b0001;
        in_data  = 32'h0000_00A5;
        e.is_eop = 1'b0; e.tx = 2'd0; e.rx = 2'd0; e.data = 8'hA5; e.sop = 1'b1; e.len = '0;
        sb.push_back(e);
        @(negedge clk);
        in_vaild = '0; in_data = '0;
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({grant, out_vaild, out_eop, out_len, out_data, out_sop, busy, err} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_burst: grant=%b vaild=%b eop=%b busy=%b, expected all 0", grant, out_vaild, out_eop, busy);
        end
        rst = 1'b0;
        drain();
    endtask

`ifdef ARB_WATCHDOG_EN
    task automatic test_watchdog();
        int n;
        exp_t e;
        apply_reset();
        in_req = 4'b0001;
        n = 0;
        while (grant !== 4'b0001 && n < 10) begin
            n++;
            @(negedge clk);
        end
        in_req = '0;
        e.is_eop = 1'b1; e.tx = '0; e.rx = '0; e.data = '0; e.sop = 1'b0; e.len = '0;
        sb.push_back(e);
        n = 0;
        while (grant === 4'b0001 && n < 100) begin
            n++;
            @(negedge clk);
        end
        err_expect++;
        vectors++;
        if (n != TO || err !== 1'b1) begin
            miscompares++;
            $display("FAIL watchdog: grant held %0d cycles err=%b, expected %0d cycles err=1", n, err, TO);
        end
        drain();
    endtask
`endif

    initial begin
        rst = 1'b1;
        in_req = '0; in_vaild = '0; in_done = '0;
        in_rx_port = '0; in_data = '0; mem_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_fairness_wrap();
        test_back_pressure();
        test_overflow();
        test_zero_beat();
        test_reset_mid_burst();
`ifdef ARB_WATCHDOG_EN
        test_watchdog();
`endif
        vectors++;
        if (sb.size() != 0 || err_count != err_expect) begin
            miscompares++;
            $display("FAIL final: pending=%0d err_pulses=%0d, expected pending=0 err_pulses=%0d", sb.size(), err_count, err_expect);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
